// File: rtl/rename_queue_pkg.sv
// Shared rename-queue types and sizing: lane count, default depth, micro-op layout.
// Types only, no logic; lane-count width is sized to hold 0..RENAME_WIDTH.
package rename_queue_pkg;

    localparam int RENAME_WIDTH            = 4;
    localparam int RENAME_QUEUE_DEPTH      = 16;
    localparam int RENAME_QUEUE_INDEX_SIZE = $clog2(RENAME_QUEUE_DEPTH);
    localparam int RENAME_LANE_CNT_W       = $clog2(RENAME_WIDTH + 1);

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [7:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } micro_op_t;

endpackage

// File: rtl/uop_compact.sv
// Packs the valid lanes of a decode group into the low lanes, in lane order, and counts them.
// Purely combinational (0 cycles); no flow control of its own. Unused output lanes are all-zero.
module uop_compact
    import rename_queue_pkg::*;
(
    input  micro_op_t [RENAME_WIDTH-1:0]      i_uops,
    output micro_op_t [RENAME_WIDTH-1:0]      o_uops,
    output logic      [RENAME_LANE_CNT_W-1:0] o_count
);

    localparam int LCW = RENAME_LANE_CNT_W;

    always_comb begin
        logic [LCW-1:0] v_n;
        v_n    = '0;
        o_uops = '0;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            if (i_uops[i].valid) begin
                for (int k = 0; k < RENAME_WIDTH; k++) begin
                    if (v_n == LCW'(k)) begin
                        o_uops[k] = i_uops[i];
                    end
                end
                v_n = v_n + LCW'(1);
            end
        end
        o_count = v_n;
    end

endmodule

// File: rtl/rename_queue.sv
// Decode->rename decoupling FIFO: packs sparse decode groups into a circular buffer, shows oldest RENAME_WIDTH uops.
// Latency 1 cycle; 0 cycles from an empty queue when RENAME_QUEUE_BYPASS_EN is defined.
// Backpressure: in_ready from registered occupancy only; out_accept never reaches uop_out or in_ready.
module rename_queue
    import rename_queue_pkg::*;
#(
    parameter int DEPTH = RENAME_QUEUE_DEPTH
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             recover,
    input  micro_op_t [RENAME_WIDTH-1:0]     uop_in,
    output logic                             in_ready,
    output micro_op_t [RENAME_WIDTH-1:0]     uop_out,
    input  logic                             out_accept,
    output logic      [$clog2(DEPTH):0]      count
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam int NW = RENAME_LANE_CNT_W;

    logic [IW-1:0] r_head;
    logic [IW-1:0] r_tail;
    logic [CW-1:0] r_count;
    micro_op_t     r_mem [DEPTH];

    micro_op_t [RENAME_WIDTH-1:0] w_cmp;
    logic [NW-1:0]                w_n_in;
    logic                         w_in_ready;
    logic [CW-1:0]                w_n_out;
    logic                         w_bypass_sel;
    logic                         w_bypass_take;
    logic                         w_enq;
    logic                         w_deq;
    logic [CW-1:0]                w_n_enq;
    logic [CW-1:0]                w_n_deq;

    uop_compact u_compact (
        .i_uops  (uop_in),
        .o_uops  (w_cmp),
        .o_count (w_n_in)
    );

    assign w_in_ready = (CW'(DEPTH) - r_count) >= CW'(RENAME_WIDTH);
    assign w_n_out    = (r_count < CW'(RENAME_WIDTH)) ? r_count : CW'(RENAME_WIDTH);

`ifdef RENAME_QUEUE_BYPASS_EN
    assign w_bypass_sel = (r_count == '0) && !recover;
`else
    assign w_bypass_sel = 1'b0;
`endif

    // A bypassed group that rename takes this cycle must not also land in mem.
    assign w_bypass_take = w_bypass_sel && out_accept && (w_n_in != '0);
    assign w_enq   = w_in_ready && !recover && (w_n_in != '0) && !w_bypass_take;
    assign w_deq   = out_accept && !recover && (r_count != '0);
    assign w_n_enq = w_enq ? CW'(w_n_in) : '0;
    assign w_n_deq = w_deq ? w_n_out : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (recover) begin
            r_head  <= r_tail;
            r_count <= '0;
        end else begin
            r_tail  <= r_tail + IW'(w_n_enq);
            r_head  <= r_head + IW'(w_n_deq);
            r_count <= r_count + w_n_enq - w_n_deq;
        end
    end

    // Storage needs no reset: every read is qualified by r_count.
    always_ff @(posedge clock) begin
        if (w_enq) begin
            for (int i = 0; i < RENAME_WIDTH; i++) begin
                if (NW'(i) < w_n_in) begin
                    r_mem[r_tail + IW'(i)] <= w_cmp[i];
                end
            end
        end
    end

    always_comb begin
        uop_out = '0;
        if (w_bypass_sel) begin
            uop_out = w_cmp;
        end else if (!recover) begin
            for (int i = 0; i < RENAME_WIDTH; i++) begin
                if (CW'(i) < r_count) begin
                    uop_out[i]       = r_mem[r_head + IW'(i)];
                    uop_out[i].valid = 1'b1;
                end
            end
        end
    end

    assign in_ready = w_in_ready;
    assign count    = r_count;

endmodule

// File: tb/tb_rename_queue.sv
// Scoreboarded bench for rename_queue: directed scenarios then randomized traffic against a queue model.
module tb_rename_queue;
    import rename_queue_pkg::*;

    localparam int W     = RENAME_WIDTH;
    localparam int DEPTH = RENAME_QUEUE_DEPTH;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int VW    = W * $bits(micro_op_t);

    typedef micro_op_t [W-1:0] grp_t;

    typedef struct packed {
        logic [VW-1:0] out;
        logic [CW-1:0] cnt;
        logic          rdy;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          recover;
    logic          out_accept;
    logic          in_ready;
    grp_t          uop_in;
    grp_t          uop_out;
    logic [CW-1:0] count;

    rename_queue #(.DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .recover    (recover),
        .uop_in     (uop_in),
        .in_ready   (in_ready),
        .uop_out    (uop_out),
        .out_accept (out_accept),
        .count      (count)
    );

    always #5 clock = ~clock;

    exp_t        exp_q[$];
    micro_op_t   model_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned tag   = 1;

    task automatic check(string name, logic [VW-1:0] act, logic [VW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Each lane carries a unique pc tag so ordering errors are visible.
    function automatic grp_t grp(logic [W-1:0] mask);
        grp_t g;
        for (int i = 0; i < W; i++) begin
            g[i].valid  = mask[i];
            g[i].pc     = tag;
            tag++;
            g[i].opcode = 8'($urandom);
            g[i].rd     = 5'($urandom);
            g[i].rs1    = 5'($urandom);
            g[i].rs2    = 5'($urandom);
        end
        return g;
    endfunction

    // Drive one cycle, record the response the queue should show, then advance the model.
    task automatic drive(bit rst, bit rec, bit acc, grp_t g);
        exp_t e;
        grp_t o;
        int   n;
        int   n_out;
        bit   bypass;
        bit   any_in;
        @(negedge clock);
        reset      = rst;
        recover    = rec;
        out_accept = acc;
        uop_in     = g;
        #1;
        o      = '0;
        bypass = 1'b0;
        any_in = 1'b0;
        for (int i = 0; i < W; i++) if (g[i].valid) any_in = 1'b1;
`ifdef RENAME_QUEUE_BYPASS_EN
        bypass = (model_q.size() == 0) && !rec;
`endif
        if (bypass) begin
            n = 0;
            for (int i = 0; i < W; i++) begin
                if (g[i].valid) begin
                    o[n] = g[i];
                    n++;
                end
            end
        end else if (!rec) begin
            for (int i = 0; i < W && i < model_q.size(); i++) o[i] = model_q[i];
        end
        e.out = o;
        e.cnt = CW'(model_q.size());
        e.rdy = (DEPTH - model_q.size()) >= W;
        exp_q.push_back(e);

        if (rst || rec) begin
            model_q.delete();
        end else begin
            n_out = acc ? ((model_q.size() < W) ? model_q.size() : W) : 0;
            if (e.rdy && !(bypass && acc && any_in)) begin
                for (int i = 0; i < W; i++) if (g[i].valid) model_q.push_back(g[i]);
            end
            repeat (n_out) void'(model_q.pop_front());
        end
    endtask

    // Monitor: compares every presented cycle against the oldest scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("uop_out",  VW'(uop_out),  e.out);
                check("count",    VW'(count),    VW'(e.cnt));
                check("in_ready", VW'(in_ready), VW'(e.rdy));
            end
        end
    end

    initial begin
        logic [W-1:0] m;
        int           thr;
        reset      = 1'b1;
        recover    = 1'b0;
        out_accept = 1'b0;
        uop_in     = '0;

        drive(0, 0, 0, grp(4'b0101));
        drive(0, 0, 0, grp(4'b0010));
        drive(0, 0, 0, grp(4'b1111));
        check("three_count", VW'(count), VW'(3));
        check("three_lane3", VW'(uop_out[3]), '0);
        drive(0, 0, 0, grp(4'b1111));
        drive(0, 0, 0, grp(4'b0011));
        drive(0, 0, 0, grp(4'b1111));
        check("full_count", VW'(count), VW'(13));
        check("full_ready", VW'(in_ready), '0);
        drive(0, 0, 1, grp('0));
        drive(0, 0, 1, grp(4'b1111));
        check("drain_count", VW'(count), VW'(9));
        check("drain_ready", VW'(in_ready), VW'(1));
        drive(0, 0, 1, grp(4'b0111));
        drive(0, 0, 1, grp(4'b1111));
        check("wrap_count", VW'(count), VW'(8));
        drive(0, 0, 0, grp(4'b0011));
        drive(0, 1, 1, grp(4'b1111));
        check("recover_count", VW'(count), VW'(10));
        check("recover_out", VW'(uop_out), '0);
        drive(0, 0, 0, grp('0));
        check("post_recover_count", VW'(count), '0);
        check("post_recover_ready", VW'(in_ready), VW'(1));

        drive(0, 0, 1, grp(4'b1011));
        drive(0, 0, 0, grp(4'b1110));
        drive(0, 0, 0, grp('0));

        drive(0, 1, 0, grp('0));
        drive(0, 0, 0, grp(4'b1111));
        drive(0, 0, 0, grp(4'b0111));
        drive(0, 0, 0, grp('0));
        check("pre_reset_count", VW'(count), VW'(7));
        drive(1, 0, 1, grp(4'b1111));
        drive(0, 0, 0, grp('0));
        check("post_reset_count", VW'(count), '0);
        check("post_reset_out", VW'(uop_out), '0);

        for (int c = 0; c < 800; c++) begin
            thr = (c < 400) ? 3 : 7;
            m   = W'($urandom);
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) < thr, grp(m));
        end

        drive(0, 0, 0, grp('0));
        #5;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
